uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its one-cycle byte strobe (rx_valid/rx_data) and assembles fixed 5-byte command frames: SOF, OP, ADDR, DATA, CHK.
- Checks the frame and presents each good frame as one command on a valid/ready interface to the register/control logic.
- Also provides resynchronisation on garbage, an inter-byte timeout, and error pulses.

Parameters:
- TIMEOUT_CLKS, 17360, maximum idle clocks allowed between bytes inside a frame (about 20 bit times at CLKS_PER_BIT=868); must be ≥2.
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe, rx_data is valid
- rx_data  in  8  received byte
- cmd_valid  out  1  command held and available
- cmd_ready  in  1  consumer accepts the command
- cmd_op  out  8  frame OP byte
- cmd_addr  out  8  frame ADDR byte
- cmd_data  out  8  frame DATA byte
- err_chk  out  1  one-cycle pulse, checksum mismatch, frame dropped
- err_ovf  out  1  one-cycle pulse, good frame dropped because the output was still occupied
- err_timeout  out  1  one-cycle pulse, frame aborted by inter-byte timeout
- busy  out  1  parser is in any state other than S_SOF

Behaviour:
- Reset: state=S_SOF; cmd_valid=0; cmd_op/addr/data=8'h00; all err_* =0; busy=0; timeout counter=0.
- States (advance only on rx_valid):
  - S_SOF: byte==SOF_BYTE goes to S_OP; any other byte is discarded.
  - S_OP: capture the OP byte, go to S_ADDR.
  - S_ADDR: capture the ADDR byte, go to S_DATA.
  - S_DATA: capture the DATA byte, go to S_CHK.
  - S_CHK: compare the byte with OP^ADDR^DATA (8-bit XOR), then go to S_SOF.
- SOF_BYTE received in S_OP..S_CHK is ordinary data; there is no mid-frame resync.
- Good frame:
  - If the output register is free, or is being emptied this cycle (cmd_valid & cmd_ready), load op/addr/data and set cmd_valid=1 on the next cycle. Latency is 1 clk after the CHK rx_valid cycle.
  - Otherwise keep the old command unchanged and pulse err_ovf next cycle.
- Bad checksum: pulse err_chk next cycle; the output register is untouched.
- Output handshake:
  - cmd_valid stays high, and cmd_* stay stable, until the cycle with cmd_ready=1.
  - cmd_valid clears the following cycle unless a new frame loads in that same cycle.
  - cmd_ready while cmd_valid=0 is ignored.
- Timeout:
  - The counter clears on every rx_valid and whenever state=S_SOF; otherwise it increments.
  - When it reaches TIMEOUT_CLKS-1 with no rx_valid: go to S_SOF, clear the counter, pulse err_timeout.
  - rx_valid in the same cycle as expiry: the byte wins, it is processed normally and there is no timeout.
  - Counter width is $clog2(TIMEOUT_CLKS).
- err_* pulses are mutually exclusive and last exactly one cycle.
- rst in any state, including mid-frame or with cmd_valid high, returns everything to reset values the next cycle; any pending command is lost.

Decomposition:
- Package uart_pkg:
  - parser_state_t enum (S_SOF, S_OP, S_ADDR, S_DATA, S_CHK, logic [2:0]).
  - SOF default constant 8'hA5.
  - FRAME_LEN=5.
  - Shared by the future uart_frame_builder on the transmit side.
- No sub-module. The XOR checksum and timeout counter are inline. The UART receiver is instantiated alongside, not inside.

Test Plan:
- Good frame: bytes A5 01 10 3C 2D, cmd_ready=1 → cmd_valid for 1 cycle, 1 clk after the last strobe, op=01 addr=10 data=3C; no err_*.
- Bad checksum: A5 01 10 3C 2C → err_chk single pulse; cmd_valid stays 0; a following good frame A5 02 20 55 77 is accepted.
- Garbage/resync: 00 FF 3C then A5 01 10 3C 2D → garbage ignored, busy=0 until A5, then the command is delivered correctly.
- Timeout: A5 01 then idle TIMEOUT_CLKS clocks → err_timeout pulse, busy drops. Repeat with a byte arriving exactly on the expiry cycle → no timeout.
- Backpressure: cmd_ready=0, send A5 01 10 3C 2D then A5 02 20 55 77 → first held stable, err_ovf on the second. Then raise cmd_ready on the exact CHK-completion cycle of a third frame → new command loaded, cmd_valid never drops.
- Reset mid-operation: assert rst after A5 01 10, and again while cmd_valid=1 → all outputs return to 0. The next complete frame parses normally.

Source files
------------

// File: rtl/uart_frame_parser_pkg.sv
// Shared UART framing types and constants.
// Used by the receive-side parser and the future transmit-side builder.
package uart_pkg;

  typedef enum logic [2:0] {
    S_SOF,
    S_OP,
    S_ADDR,
    S_DATA,
    S_CHK
  } parser_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN   = 5;

  function automatic logic [7:0] frame_chk(
    input logic [7:0] op,
    input logic [7:0] addr,
    input logic [7:0] data
  );
    return op ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Command valid/ready bundle between the frame parser and its consumer.
// master: parser drives cmd_valid/op/addr/data; slave: consumer drives cmd_ready.
interface uart_frame_parser_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/uart_frame_parser.sv
// Assembles 5-byte SOF/OP/ADDR/DATA/CHK frames from the UART byte strobe.
// Ports: clk, rst (sync, high), rx_valid/rx_data in, cmd (master) out,
// err_chk/err_ovf/err_timeout one-cycle pulses, busy = mid-frame.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 17360,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  uart_frame_parser_if.master        cmd,
  output logic                       err_chk,
  output logic                       err_ovf,
  output logic                       err_timeout,
  output logic                       busy
);

  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CLKS - 1);

  parser_state_t state_q;
  parser_state_t state_d;

  logic [CW-1:0] cnt_q;
  logic [7:0]    op_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;

  logic expire;
  logic frame_done;
  logic chk_ok;
  logic take;
  logic load;
  logic drop;
  logic bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SOF;
    end else begin
      state_q <= state_d;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout,
  // since expire is qualified with !rx_valid.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      expire: state_d = S_SOF;
      rx_valid: begin
        unique case (state_q)
          S_SOF:   state_d = (rx_data == SOF_BYTE) ? S_OP : S_SOF;
          S_OP:    state_d = S_ADDR;
          S_ADDR:  state_d = S_DATA;
          S_DATA:  state_d = S_CHK;
          S_CHK:   state_d = S_SOF;
          default: state_d = S_SOF;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    expire     = (state_q != S_SOF) && !rx_valid && (cnt_q == CNT_MAX);
    frame_done = (state_q == S_CHK) && rx_valid;
    chk_ok     = (rx_data == frame_chk(op_q, addr_q, data_q));
    take       = cmd.cmd_valid && cmd.cmd_ready;
    load       = frame_done && chk_ok && (!cmd.cmd_valid || take);
    drop       = frame_done && chk_ok && !load;
    bad        = frame_done && !chk_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      op_q          <= 8'h00;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_op    <= 8'h00;
      cmd.cmd_addr  <= 8'h00;
      cmd.cmd_data  <= 8'h00;
      err_chk       <= 1'b0;
      err_ovf       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      if (rx_valid || (state_q == S_SOF) || expire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (rx_valid && (state_q == S_OP))   op_q   <= rx_data;
      if (rx_valid && (state_q == S_ADDR)) addr_q <= rx_data;
      if (rx_valid && (state_q == S_DATA)) data_q <= rx_data;
      if (load) begin
        cmd.cmd_valid <= 1'b1;
        cmd.cmd_op    <= op_q;
        cmd.cmd_addr  <= addr_q;
        cmd.cmd_data  <= data_q;
      end else if (take) begin
        cmd.cmd_valid <= 1'b0;
      end
      err_chk     <= bad;
      err_ovf     <= drop;
      err_timeout <= expire;
    end
  end

  assign busy = (state_q != S_SOF);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser with directed frames.
// Expected commands/errors are queued by stimulus, popped by a monitor.
module tb_uart_frame_parser;

  localparam int T = 20;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       err_chk;
  logic       err_ovf;
  logic       err_timeout;
  logic       busy;

  uart_frame_parser_if cif ();

  uart_frame_parser #(
    .TIMEOUT_CLKS(T),
    .SOF_BYTE    (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cmd        (cif.master),
    .err_chk    (err_chk),
    .err_ovf    (err_ovf),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  cmd_t exp_cmd[$];
  int   exp_err[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(addr);
    send_byte(data);
    send_byte(chk);
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [7:0] addr,
                          input logic [7:0] data);
    cmd_t c;
    c.op   = op;
    c.addr = addr;
    c.data = data;
    exp_cmd.push_back(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0 = checksum, 1 = overflow, 2 = timeout
  always @(negedge clk) begin
    if (!rst) begin
      if (cif.cmd_valid && cif.cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL cmd_unexpected: got %h expected none",
                   {cif.cmd_op, cif.cmd_addr, cif.cmd_data});
        end else begin
          check("cmd_scoreboard",
                {8'h00, cif.cmd_op, cif.cmd_addr, cif.cmd_data},
                {8'h00, exp_cmd.pop_front()});
        end
      end
      if (err_chk || err_ovf || err_timeout) begin
        if (exp_err.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_unexpected: got %b expected none",
                   {err_chk, err_ovf, err_timeout});
        end else begin
          int k;
          k = exp_err.pop_front();
          check("err_scoreboard", {29'd0, err_chk, err_ovf, err_timeout},
                (k == 0) ? 32'd4 : (k == 1) ? 32'd2 : 32'd1);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    cif.cmd_ready = 1'b0;
    idle(3);
    check("rst_valid", {31'd0, cif.cmd_valid}, 32'd0);
    check("rst_cmd", {8'h00, cif.cmd_op, cif.cmd_addr, cif.cmd_data}, 32'd0);
    check("rst_err", {29'd0, err_chk, err_ovf, err_timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(1);

    // good frame
    cif.cmd_ready = 1'b1;
    push_cmd(8'h01, 8'h10, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    check("good_lat", {31'd0, cif.cmd_valid}, 32'd1);
    check("good_op", {24'd0, cif.cmd_op}, 32'h01);
    idle(1);
    check("good_one_cycle", {31'd0, cif.cmd_valid}, 32'd0);

    // bad checksum, then a good frame
    exp_err.push_back(0);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2C);
    check("chk_pulse", {31'd0, err_chk}, 32'd1);
    check("chk_no_valid", {31'd0, cif.cmd_valid}, 32'd0);
    idle(1);
    check("chk_pulse_end", {31'd0, err_chk}, 32'd0);
    push_cmd(8'h02, 8'h20, 8'h55);
    send_frame(8'h02, 8'h20, 8'h55, 8'h77);
    check("after_chk_valid", {31'd0, cif.cmd_valid}, 32'd1);
    idle(2);

    // garbage then resync
    send_byte(8'h00);
    check("garbage_busy0", {31'd0, busy}, 32'd0);
    send_byte(8'hFF);
    send_byte(8'h3C);
    check("garbage_busy2", {31'd0, busy}, 32'd0);
    push_cmd(8'h01, 8'h10, 8'h3C);
    send_byte(8'hA5);
    check("sof_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h2D);
    check("resync_valid", {31'd0, cif.cmd_valid}, 32'd1);
    idle(2);

    // timeout
    exp_err.push_back(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(T - 1);
    check("to_not_yet", {31'd0, err_timeout}, 32'd0);
    check("to_busy_before", {31'd0, busy}, 32'd1);
    idle(1);
    check("to_pulse", {31'd0, err_timeout}, 32'd1);
    check("to_busy_after", {31'd0, busy}, 32'd0);
    idle(2);

    // byte on the expiry cycle wins
    push_cmd(8'h01, 8'h10, 8'h3C);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (T - 2) @(posedge clk);
    send_byte(8'h10);
    check("edge_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h3C);
    send_byte(8'h2D);
    check("edge_valid", {31'd0, cif.cmd_valid}, 32'd1);
    idle(2);

    // backpressure and overflow
    cif.cmd_ready = 1'b0;
    push_cmd(8'h01, 8'h10, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    check("bp_valid", {31'd0, cif.cmd_valid}, 32'd1);
    exp_err.push_back(1);
    send_frame(8'h02, 8'h20, 8'h55, 8'h77);
    check("ovf_pulse", {31'd0, err_ovf}, 32'd1);
    check("ovf_hold", {8'h00, cif.cmd_op, cif.cmd_addr, cif.cmd_data},
          32'h0001103C);
    check("ovf_valid", {31'd0, cif.cmd_valid}, 32'd1);
    push_cmd(8'h03, 8'h30, 8'h0F);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h30);
    send_byte(8'h0F);
    @(posedge clk);
    #1;
    rx_valid      = 1'b1;
    rx_data       = 8'h3C;
    cif.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("swap_valid", {31'd0, cif.cmd_valid}, 32'd1);
    check("swap_cmd", {8'h00, cif.cmd_op, cif.cmd_addr, cif.cmd_data},
          32'h0003300F);
    idle(1);
    check("swap_drain", {31'd0, cif.cmd_valid}, 32'd0);

    // reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    idle(1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // reset with a pending command
    cif.cmd_ready = 1'b0;
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    check("pend_valid", {31'd0, cif.cmd_valid}, 32'd1);
    rst = 1'b1;
    idle(1);
    check("pend_rst_valid", {31'd0, cif.cmd_valid}, 32'd0);
    check("pend_rst_cmd", {8'h00, cif.cmd_op, cif.cmd_addr, cif.cmd_data},
          32'd0);
    rst           = 1'b0;
    cif.cmd_ready = 1'b1;
    push_cmd(8'h02, 8'h20, 8'h55);
    send_frame(8'h02, 8'h20, 8'h55, 8'h77);
    check("post_rst_valid", {31'd0, cif.cmd_valid}, 32'd1);
    idle(3);

    check("cmd_queue_empty", exp_cmd.size(), 32'd0);
    check("err_queue_empty", exp_err.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
